imm_enc: RTL
============

Name: imm_enc

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate into the scattered immediate fields of a RISC-V instruction template.
- Used by the self-test/boot-ROM instruction builder and by verification to build instruction streams.
- Streams over valid/ready, buffers up to 2 encoded words, flags immediates that cannot be represented in the selected format, and keeps saturating statistics counters.

Parameters:
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_base  input  32  instruction template (opcode/rd/rs/funct); its immediate-field bits are ignored.
- in_imm  input  32  immediate value.
- in_imm_src  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 invalid.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_instr  output  32  encoded instruction.
- out_range_err  output  1  immediate not representable or format invalid (travels with out_instr).
- cnt_enc  output  CNT_W  accepted requests, saturating.
- cnt_err  output  CNT_W  accepted requests with range error, saturating.

Behaviour:
- Reset (asynchronous, active-high clock/reset as decided): buffer empty; out_valid=0, out_instr=0, out_range_err=0, cnt_enc=0, cnt_err=0, in_ready=1.
- Field packing (non-immediate bits come from in_base):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Invalid src: out_instr=in_base unchanged, err=1.
- Range error:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - On error the truncated bits are still packed as above.
- Encoding is combinational on the inputs. The result {instr, err} is written into a 2-entry buffer on acceptance.
- FSM on occupancy:
  - EMPTY --push--> ONE.
  - ONE --push&!pop--> FULL.
  - ONE --pop&!push--> EMPTY.
  - ONE --push&pop--> ONE.
  - FULL --pop--> ONE.
- in_ready = (state != FULL), driven from a register, with no combinational path from out_ready. In FULL, a simultaneous pop does not enable a push in the same cycle.
- Latency: a request accepted at edge N appears at out_valid/out_instr after edge N; no same-cycle bypass.
- Output stability: while out_valid=1 && out_ready=0, out_instr/out_range_err hold stable.
- Ordering: strict FIFO order.
- Counters: cnt_enc +1 per acceptance; cnt_err +1 per acceptance with err. Both saturate at all-ones.
- Reset mid-operation: buffered words are discarded and counters cleared immediately.

Optional Feature:
- Macro IMM_ENC_ROUNDTRIP_CHECK_EN.
- When defined:
  - Instantiates immgen on the encoder output with the same imm_src and compares its imm_ext against in_imm.
  - Adds output port rt_mismatch (1 bit), registered and sticky until reset. It sets when an accepted request with err=0 decodes to a value != in_imm.
  - Adds a simulation assertion on the same condition.
- When undefined: no port, no immgen instance, no assertion.

Decomposition:
- Package imm_enc_pkg:
  - Enum imm_src_e: IMM_I=3'b000, IMM_S, IMM_B, IMM_U, IMM_J. The same encoding immgen uses.
  - Occupancy-state enum: EMPTY/ONE/FULL.
  - Packed struct enc_entry_t {logic [31:0] instr; logic err;}.
- Sub-module: imm_enc_pack, purely combinational, handling field packing plus range check. The top holds the buffer, FSM and counters.

Test Plan:
- I, base 0x00012383, imm 0xFFFFFFFF -> out_instr 0xFFF12383, err 0; imm 0x00000800 -> err 1.
- S, base 0x00F12023, imm 0x00000006 -> 0x00F12323; B, base 0x00512063, imm 0xFFFFFFFC -> 0xFE512EE3; B imm 0x00000003 -> err 1, cnt_err increments.
- U, base 0x00000037, imm 0x12345000 -> 0x12345037; imm 0x12345001 -> err 1. J, base 0x0000006F, imm 0xFFFFFFFE -> 0xFFFFF06F. Src 3'b111 -> base unchanged, err 1.
- Backpressure: out_ready=0, drive 3 back-to-back requests -> in_ready low after 2 acceptances, outputs stable. Then out_ready=1 -> both words drain in order, in_ready returns to 1 the cycle after the first pop.
- Saturation: force CNT_W=4, push 20 requests -> cnt_enc holds at 0xF. Assert rst with 2 words buffered -> out_valid=0 and counters 0 immediately, before the next clock edge.
- With IMM_ENC_ROUNDTRIP_CHECK_EN: 1000 random valid (src, imm) pairs -> rt_mismatch stays 0.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared types for the immediate encoder: format selector, buffer occupancy
// states, buffered entry layout and a sign-run helper used by the range check.
package imm_enc_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_src_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } enc_entry_t;

   // True when every bit from position lsb up to 31 matches the sign bit,
   // i.e. the value fits a signed field whose top bit sits at lsb.
   function automatic logic isSignRun(input logic [31:0] v, input int lsb);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i >= lsb && v[i] != v[31]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational field packer: scatters an immediate into the RISC-V immediate
// fields of a template and flags values the format cannot represent.
// With IMM_ENC_ROUNDTRIP_CHECK_EN this file also provides the immgen decoder.
module imm_enc_pack
   import imm_enc_pkg::*;
(
   input  logic [31:0] i_base,
   input  logic [31:0] i_imm,
   input  logic [2:0]  i_immSrc,
   output logic [31:0] o_instr,
   output logic        o_rangeErr
);

   // Truncated bits are still packed on a range error so the word stays
   // predictable; only the flag reports the loss.
   always_comb begin
      o_instr    = i_base;
      o_rangeErr = 1'b1;
      case (i_immSrc)
         IMM_I: begin
            o_instr    = {i_imm[11:0], i_base[19:0]};
            o_rangeErr = !isSignRun(i_imm, 11);
         end
         IMM_S: begin
            o_instr    = {i_imm[11:5], i_base[24:12], i_imm[4:0], i_base[6:0]};
            o_rangeErr = !isSignRun(i_imm, 11);
         end
         IMM_B: begin
            o_instr    = {i_imm[12], i_imm[10:5], i_base[24:12],
                          i_imm[4:1], i_imm[11], i_base[6:0]};
            o_rangeErr = !isSignRun(i_imm, 12) || i_imm[0];
         end
         IMM_U: begin
            o_instr    = {i_imm[31:12], i_base[11:0]};
            o_rangeErr = (i_imm[11:0] != 12'd0);
         end
         IMM_J: begin
            o_instr    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                          i_base[11:0]};
            o_rangeErr = !isSignRun(i_imm, 20) || i_imm[0];
         end
         default: begin
            o_instr    = i_base;
            o_rangeErr = 1'b1;
         end
      endcase
   end

endmodule

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
module immgen
   import imm_enc_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [2:0]  i_imm_src,
   output logic [31:0] o_imm_ext
);

   logic unusedOpcode;
   assign unusedOpcode = ^i_instr[6:0];

   always_comb begin
      o_imm_ext = 32'd0;
      case (i_imm_src)
         IMM_I: o_imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S: o_imm_ext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B: o_imm_ext = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: o_imm_ext = {i_instr[31:12], 12'd0};
         IMM_J: o_imm_ext = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm_ext = 32'd0;
      endcase
   end

endmodule
`endif

// File: rtl/imm_enc.sv
// Streaming immediate encoder: packs requests, buffers up to two encoded words
// in FIFO order and keeps saturating statistics. Optional IMM_ENC_ROUNDTRIP_CHECK_EN.
module imm_enc
   import imm_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_base,
   input  logic [31:0]      in_imm,
   input  logic [2:0]       in_imm_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_range_err,
   output logic [CNT_W-1:0] cnt_enc,
   output logic [CNT_W-1:0] cnt_err
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
   ,
   output logic             rt_mismatch
`endif
);

   logic [31:0] w_packInstr;
   logic        w_packErr;
   logic        w_push;
   logic        w_pop;

   occ_state_e  r_state;
   occ_state_e  w_nextState;
   logic        r_inReady;
   enc_entry_t  r_mem [2];
   logic        r_wrPtr;
   logic        r_rdPtr;
   logic [CNT_W-1:0] r_cntEnc;
   logic [CNT_W-1:0] r_cntErr;

   imm_enc_pack u_pack (
      .i_base     (in_base),
      .i_imm      (in_imm),
      .i_immSrc   (in_imm_src),
      .o_instr    (w_packInstr),
      .o_rangeErr (w_packErr)
   );

   assign w_push        = in_valid && r_inReady;
   assign w_pop         = out_valid && out_ready;
   assign in_ready      = r_inReady;
   assign out_valid     = (r_state != EMPTY);
   assign out_instr     = r_mem[r_rdPtr].instr;
   assign out_range_err = r_mem[r_rdPtr].err;
   assign cnt_enc       = r_cntEnc;
   assign cnt_err       = r_cntErr;

   // in_ready is registered from the next state so out_ready never reaches it
   // combinationally; a pop while FULL therefore frees space one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= EMPTY;
         r_inReady <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState != FULL);
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         EMPTY: if (w_push) w_nextState = ONE;
         ONE: begin
            if (w_push && !w_pop)      w_nextState = FULL;
            else if (w_pop && !w_push) w_nextState = EMPTY;
         end
         FULL:  if (w_pop) w_nextState = ONE;
         default: w_nextState = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= '{instr: w_packInstr, err: w_packErr};
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) r_rdPtr <= ~r_rdPtr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cntEnc <= '0;
         r_cntErr <= '0;
      end else begin
         if (w_push && r_cntEnc != '1)
            r_cntEnc <= r_cntEnc + CNT_W'(1);
         if (w_push && w_packErr && r_cntErr != '1)
            r_cntErr <= r_cntErr + CNT_W'(1);
      end
   end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
   logic [31:0] w_rtImm;
   logic        w_rtDiff;
   logic        r_rtMismatch;

   immgen u_immgen (
      .i_instr   (w_packInstr),
      .i_imm_src (in_imm_src),
      .o_imm_ext (w_rtImm)
   );

   assign w_rtDiff    = w_push && !w_packErr && (w_rtImm != in_imm);
   assign rt_mismatch = r_rtMismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_rtMismatch <= 1'b0;
      else if (w_rtDiff) r_rtMismatch <= 1'b1;
   end

   rtCheck: assert property (@(posedge clk) disable iff (rst) !w_rtDiff);
`endif

endmodule
